// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM encoding for the UART command register bank.
// Contents: framing byte constants (start, write/read opcodes, ACK/NAK) and
// the command FSM state type.
package uart_cmd_pkg;

   localparam logic [7:0] StartU = 8'h53;
   localparam logic [7:0] StartL = 8'h73;
   localparam logic [7:0] OpWU   = 8'h57;
   localparam logic [7:0] OpWL   = 8'h77;
   localparam logic [7:0] OpRU   = 8'h52;
   localparam logic [7:0] OpRL   = 8'h72;
   localparam logic [7:0] Ack    = 8'h80;
   localparam logic [7:0] Nak    = 8'h81;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StData,
      StTx
   } state_e;

endpackage

// File: rtl/uart_cmd_regbank_if.sv
// Byte-level link between a UART and the command register bank.
// Signals:
//   rx_data/rx_valid/rx_err : received byte, 1-cycle valid strobe, framing error
//   tx_idle                 : transmitter can accept a byte
//   tx_data/tx_start        : byte to send, 1-cycle start strobe
// Modports: master = UART side, slave = command decoder side.
interface uart_cmd_regbank_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       tx_idle;
   logic [7:0] tx_data;
   logic       tx_start;

   modport master (
      output rx_data, rx_valid, rx_err, tx_idle,
      input  tx_data, tx_start
   );

   modport slave (
      input  rx_data, rx_valid, rx_err, tx_idle,
      output tx_data, tx_start
   );

endinterface

// File: rtl/uart_tx_seq.sv
// Response byte sequencer: holds up to QueueW/8 queued bytes and hands them to the
// UART one at a time, first byte in the top bits of the load vector.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   load_i                 : load a new response (only issued while done_o=1)
//   load_data_i            : response bytes, first byte in the most significant position
//   load_cnt_i             : number of bytes to send
//   tx_idle_i              : UART transmitter ready
//   tx_data_o, tx_start_o  : byte to send and its 1-cycle start strobe
//   done_o                 : queue empty
module uart_tx_seq #(
   parameter int unsigned QueueW = 40,
   parameter int unsigned CntW   = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [QueueW-1:0] load_data_i,
   input  logic [CntW-1:0]   load_cnt_i,
   input  logic              tx_idle_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_start_o,
   output logic              done_o
);

   logic [QueueW-1:0] queue_q, queue_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;

   always_comb begin
      queue_d    = queue_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      if (load_i) begin
         queue_d = load_data_i;
         cnt_d   = load_cnt_i;
      end else if ((cnt_q != '0) && tx_idle_i && !tx_start_q) begin
         // Back-to-back starts are blocked so the UART gets a cycle to drop tx_idle.
         tx_start_d = 1'b1;
         tx_data_d  = queue_q[QueueW-1 -: 8];
         queue_d    = queue_q << 8;
         cnt_d      = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         queue_q    <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         queue_q    <= queue_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign tx_data_o  = tx_data_q;
   assign tx_start_o = tx_start_q;
   assign done_o     = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_regbank.sv
// Byte-level command decoder: parses 'S' + op + addr [+ data] frames from the UART
// into a bank of NumRegs registers of DataW bits and answers with ACK/NAK (+ read data).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   uart_if       : UART byte interface (slave side)
//   reg_q_o       : flattened register bank, reg i at [i*DataW +: DataW]
//   wr_strobe_o   : 1-cycle pulse on the register just written
//   led_o         : register 0 bits [7:0]
//   timeout_o     : 1-cycle pulse when a command is aborted (idle timeout or rx_err)
//   busy_o        : FSM not idle
module uart_cmd_regbank
   import uart_cmd_pkg::*;
#(
   parameter int unsigned DataW      = 32,
   parameter int unsigned NumRegs    = 4,
   parameter int unsigned TimeoutCyc = 12000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   uart_cmd_regbank_if.slave        uart_if,
   output logic [NumRegs*DataW-1:0] reg_q_o,
   output logic [NumRegs-1:0]       wr_strobe_o,
   output logic [7:0]               led_o,
   output logic                     timeout_o,
   output logic                     busy_o
);

   localparam int unsigned Bytes  = DataW / 8;
   localparam int unsigned AddrW  = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam int unsigned QueueW = (Bytes + 1) * 8;
   localparam int unsigned ToW    = $clog2(TimeoutCyc + 1);

   state_e                        state_q, state_d;
   logic [NumRegs-1:0][DataW-1:0] regs_q, regs_d;
   logic [DataW-1:0]              asm_q, asm_d;
   logic [AddrW-1:0]              addr_q, addr_d;
   logic [4:0]                    byte_cnt_q, byte_cnt_d;
   logic [ToW-1:0]                to_cnt_q, to_cnt_d;
   logic                          is_write_q, is_write_d;
   logic [NumRegs-1:0]            wr_strobe_q, wr_strobe_d;
   logic                          timeout_q, timeout_d;

   logic              load;
   logic [QueueW-1:0] load_data;
   logic [4:0]        load_cnt;
   logic              tx_done;
   logic [DataW+7:0]  asm_shift;
   logic              addr_ok;
   logic              active;

   // Full 8-bit compare: out-of-range addresses never alias onto a valid register.
   assign addr_ok = (32'(uart_if.rx_data) < NumRegs);
   assign active  = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);

   always_comb begin
      state_d     = state_q;
      regs_d      = regs_q;
      asm_d       = asm_q;
      addr_d      = addr_q;
      byte_cnt_d  = byte_cnt_q;
      to_cnt_d    = '0;
      is_write_d  = is_write_q;
      wr_strobe_d = '0;
      timeout_d   = 1'b0;
      load        = 1'b0;
      load_data   = '0;
      load_cnt    = '0;
      asm_shift   = {asm_q, uart_if.rx_data};

      if ((state_q != StTx) && uart_if.rx_err) begin
         state_d   = StIdle;
         timeout_d = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (uart_if.rx_valid &&
                   (uart_if.rx_data == StartU || uart_if.rx_data == StartL)) begin
                  state_d = StCmd;
               end
            end
            StCmd: begin
               if (uart_if.rx_valid) begin
                  if (uart_if.rx_data == OpWU || uart_if.rx_data == OpWL) begin
                     is_write_d = 1'b1;
                     state_d    = StAddr;
                  end else if (uart_if.rx_data == OpRU || uart_if.rx_data == OpRL) begin
                     is_write_d = 1'b0;
                     state_d    = StAddr;
                  end else begin
                     load      = 1'b1;
                     load_data = {Nak, {DataW{1'b0}}};
                     load_cnt  = 5'd1;
                     state_d   = StTx;
                  end
               end
            end
            StAddr: begin
               if (uart_if.rx_valid) begin
                  if (!addr_ok) begin
                     load      = 1'b1;
                     load_data = {Nak, {DataW{1'b0}}};
                     load_cnt  = 5'd1;
                     state_d   = StTx;
                  end else if (is_write_q) begin
                     addr_d     = uart_if.rx_data[AddrW-1:0];
                     byte_cnt_d = '0;
                     state_d    = StData;
                  end else begin
                     load      = 1'b1;
                     load_data = {Ack, regs_q[uart_if.rx_data[AddrW-1:0]]};
                     load_cnt  = 5'(Bytes + 1);
                     state_d   = StTx;
                  end
               end
            end
            StData: begin
               if (uart_if.rx_valid) begin
                  asm_d = asm_shift[DataW-1:0];
                  if (byte_cnt_q == 5'(Bytes - 1)) begin
                     regs_d[addr_q]      = asm_shift[DataW-1:0];
                     wr_strobe_d[addr_q] = 1'b1;
                     load                = 1'b1;
                     load_data           = {Ack, {DataW{1'b0}}};
                     load_cnt            = 5'd1;
                     state_d             = StTx;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end
            StTx: begin
               if (tx_done) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase

         // Idle-gap watchdog; a byte in the expiry cycle wins because this only runs without one.
         if (active && !uart_if.rx_valid) begin
            if (to_cnt_q == ToW'(TimeoutCyc - 1)) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         regs_q      <= '0;
         asm_q       <= '0;
         addr_q      <= '0;
         byte_cnt_q  <= '0;
         to_cnt_q    <= '0;
         is_write_q  <= 1'b0;
         wr_strobe_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         regs_q      <= regs_d;
         asm_q       <= asm_d;
         addr_q      <= addr_d;
         byte_cnt_q  <= byte_cnt_d;
         to_cnt_q    <= to_cnt_d;
         is_write_q  <= is_write_d;
         wr_strobe_q <= wr_strobe_d;
         timeout_q   <= timeout_d;
      end
   end

   uart_tx_seq #(
      .QueueW (QueueW),
      .CntW   (5)
   ) u_tx_seq (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (load),
      .load_data_i (load_data),
      .load_cnt_i  (load_cnt),
      .tx_idle_i   (uart_if.tx_idle),
      .tx_data_o   (uart_if.tx_data),
      .tx_start_o  (uart_if.tx_start),
      .done_o      (tx_done)
   );

   assign reg_q_o     = regs_q;
   assign wr_strobe_o = wr_strobe_q;
   assign led_o       = regs_q[0][7:0];
   assign timeout_o   = timeout_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_regbank.sv
// Directed bench for uart_cmd_regbank: a small UART model logs every started byte
// and drops tx_idle for a few cycles after each start; expected values are hand-computed.
module tb_uart_cmd_regbank;

   localparam int unsigned DataW   = 32;
   localparam int unsigned NumRegs = 4;
   localparam int unsigned ToCyc   = 100;

   logic                     clk;
   logic                     rst_n;
   logic [NumRegs*DataW-1:0] reg_q;
   logic [NumRegs-1:0]       wr_strobe;
   logic [7:0]               led;
   logic                     timeout;
   logic                     busy;

   uart_cmd_regbank_if uif ();

   uart_cmd_regbank #(
      .DataW      (DataW),
      .NumRegs    (NumRegs),
      .TimeoutCyc (ToCyc)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .uart_if     (uif),
      .reg_q_o     (reg_q),
      .wr_strobe_o (wr_strobe),
      .led_o       (led),
      .timeout_o   (timeout),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] tx_log[$];
   bit         force_busy = 1'b0;
   int         busy_cnt   = 0;
   int         strobe_cnt[NumRegs];
   int         to_pulses  = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART transmitter model and pulse monitors.
   initial begin
      uif.tx_idle = 1'b1;
      for (int i = 0; i < NumRegs; i++) strobe_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (uif.tx_start === 1'b1) begin
            tx_log.push_back(uif.tx_data);
            busy_cnt = 3;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         uif.tx_idle = (busy_cnt == 0) && !force_busy;
         for (int i = 0; i < NumRegs; i++) if (wr_strobe[i] === 1'b1) strobe_cnt[i]++;
         if (timeout === 1'b1) to_pulses++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      uif.rx_data  = b;
      uif.rx_valid = 1'b1;
      @(negedge clk);
      uif.rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input string tag, input int n, input int budget);
      int k = 0;
      while (tx_log.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq(tag, 128'(tx_log.size()), 128'(n));
   endtask

   logic [7:0] exp_rd[5];
   logic [7:0] exp_rd2[5];
   int         to_before;

   initial begin
      exp_rd  = '{8'h80, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp_rd2 = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
      rst_n        = 1'b0;
      uif.rx_data  = 8'h53;
      uif.rx_valid = 1'b0;
      uif.rx_err   = 1'b0;

      // Reset with rx_valid toggling.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         uif.rx_valid = ~uif.rx_valid;
      end
      @(negedge clk);
      check_eq("rst_regs", 128'(reg_q), 128'(0));
      check_eq("rst_txs", 128'(uif.tx_start), 128'(0));
      check_eq("rst_txd", 128'(uif.tx_data), 128'(0));
      check_eq("rst_misc", 128'({wr_strobe, timeout, busy}), 128'(0));
      uif.rx_valid = 1'b0;
      rst_n        = 1'b1;
      idle(2);
      check_eq("post_rst_led", 128'(led), 128'(0));
      check_eq("post_rst_busy", 128'(busy), 128'(0));

      // Write reg0.
      tx_log.delete();
      send_byte(8'h53); send_byte(8'h57); send_byte(8'h00);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      check_eq("wr_strobe", 128'(wr_strobe), 128'(4'b0001));
      check_eq("wr_reg0", 128'(reg_q[31:0]), 128'(32'hDEADBEEF));
      check_eq("wr_led", 128'(led), 128'(8'hEF));
      check_eq("ack_not_early", 128'(uif.tx_start), 128'(0));
      @(negedge clk);
      check_eq("wr_strobe_end", 128'(wr_strobe), 128'(0));
      check_eq("ack_start", 128'(uif.tx_start), 128'(1));
      check_eq("ack_data", 128'(uif.tx_data), 128'(8'h80));
      idle(10);
      check_eq("wr_busy", 128'(busy), 128'(0));
      check_eq("wr_strobe_cnt", 128'(strobe_cnt[0]), 128'(1));
      check_eq("wr_tx_cnt", 128'(tx_log.size()), 128'(1));

      // Read reg0 with the transmitter held busy first.
      tx_log.delete();
      force_busy = 1'b1;
      send_byte(8'h73); send_byte(8'h72); send_byte(8'h00);
      idle(50);
      check_eq("rd_held", 128'(tx_log.size()), 128'(0));
      check_eq("rd_held_busy", 128'(busy), 128'(1));
      force_busy = 1'b0;
      wait_tx("rd_cnt", 5, 200);
      for (int i = 0; i < 5; i++) check_eq("rd_byte", 128'(tx_log[i]), 128'(exp_rd[i]));
      idle(5);
      check_eq("rd_busy", 128'(busy), 128'(0));

      // Bad opcode.
      tx_log.delete();
      send_byte(8'h53); send_byte(8'h41);
      wait_tx("badop_cnt", 1, 50);
      check_eq("badop_nak", 128'(tx_log[0]), 128'(8'h81));
      idle(10);

      // Out-of-range address.
      tx_log.delete();
      send_byte(8'h53); send_byte(8'h57); send_byte(8'h04);
      wait_tx("badaddr_cnt", 1, 50);
      check_eq("badaddr_nak", 128'(tx_log[0]), 128'(8'h81));
      idle(10);
      check_eq("badaddr_strobe", 128'(strobe_cnt[0] + strobe_cnt[1] + strobe_cnt[2]
                                       + strobe_cnt[3]), 128'(1));

      // Stray byte in idle.
      tx_log.delete();
      send_byte(8'h41);
      idle(10);
      check_eq("stray_tx", 128'(tx_log.size()), 128'(0));
      check_eq("stray_busy", 128'(busy), 128'(0));
      check_eq("stray_led", 128'(led), 128'(8'hEF));

      // Timeout after ToCyc silent cycles.
      to_before = to_pulses;
      send_byte(8'h53); send_byte(8'h57); send_byte(8'h01); send_byte(8'hAA);
      idle(ToCyc - 1);
      check_eq("to_not_yet", 128'({busy, timeout}), 128'(2'b10));
      @(negedge clk);
      check_eq("to_pulse", 128'({busy, timeout}), 128'(2'b01));
      @(negedge clk);
      check_eq("to_pulse_end", 128'(timeout), 128'(0));
      idle(5);
      check_eq("to_no_tx", 128'(tx_log.size()), 128'(0));
      check_eq("to_reg1", 128'(reg_q[63:32]), 128'(0));
      check_eq("to_cnt", 128'(to_pulses - to_before), 128'(1));

      // Byte on the expiry cycle keeps the command alive.
      to_before = to_pulses;
      send_byte(8'h53); send_byte(8'h57); send_byte(8'h01); send_byte(8'hAA);
      idle(ToCyc - 2);
      send_byte(8'hBB);
      check_eq("to_saved", 128'({busy, timeout}), 128'(2'b10));
      send_byte(8'hCC); send_byte(8'hDD);
      wait_tx("to_saved_ack", 1, 50);
      check_eq("to_saved_reg1", 128'(reg_q[63:32]), 128'(32'hAABBCCDD));
      idle(10);
      check_eq("to_saved_cnt", 128'(to_pulses - to_before), 128'(0));

      // rx_err mid-data aborts and wins over a simultaneous byte.
      tx_log.delete();
      send_byte(8'h53); send_byte(8'h57); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
      @(negedge clk);
      uif.rx_err   = 1'b1;
      uif.rx_valid = 1'b1;
      uif.rx_data  = 8'h33;
      @(negedge clk);
      uif.rx_err   = 1'b0;
      uif.rx_valid = 1'b0;
      check_eq("err_abort", 128'({busy, timeout}), 128'(2'b01));
      idle(3);
      check_eq("err_no_tx", 128'(tx_log.size()), 128'(0));
      send_byte(8'h53); send_byte(8'h57); send_byte(8'h02);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      wait_tx("err_ack", 1, 50);
      check_eq("err_reg2", 128'(reg_q[95:64]), 128'(32'h01020304));
      idle(10);

      // Bytes arriving during TX are dropped.
      tx_log.delete();
      force_busy = 1'b1;
      send_byte(8'h73); send_byte(8'h52); send_byte(8'h02);
      send_byte(8'h53); send_byte(8'h57); send_byte(8'h03);
      idle(5);
      force_busy = 1'b0;
      wait_tx("drop_cnt", 5, 200);
      for (int i = 0; i < 5; i++) check_eq("drop_byte", 128'(tx_log[i]), 128'(exp_rd2[i]));
      idle(10);
      check_eq("drop_busy", 128'(busy), 128'(0));
      check_eq("drop_strobe3", 128'(strobe_cnt[3]), 128'(0));

      // Reset in the middle of a read response.
      tx_log.delete();
      force_busy = 1'b1;
      send_byte(8'h73); send_byte(8'h72); send_byte(8'h00);
      idle(3);
      check_eq("mid_rd_busy", 128'(busy), 128'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_regs", 128'(reg_q), 128'(0));
      check_eq("mid_rst_state", 128'({busy, uif.tx_start}), 128'(0));
      force_busy = 1'b0;
      idle(20);
      rst_n = 1'b1;
      idle(20);
      check_eq("mid_rst_tx", 128'(tx_log.size()), 128'(0));
      check_eq("mid_rst_led", 128'(led), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
